can_tx_scheduler: RTL and testbench
===================================

# can_tx_scheduler

Transmit scheduler that shares the single CAN frame transmitter among `NUM_MB` transmit mailboxes. It selects the pending mailbox with the numerically lowest 11-bit identifier, which is the highest CAN priority. It hands that frame to the transmitter through a start/outcome handshake and re-arbitrates after arbitration loss or error. It enforces the interframe holdoff before the next start. The block sits between the mailbox register file and the frame transmitter/bit-stuffer whose bus activity the assertion monitor checks.

## Interface
Parameters:
- `NUM_MB`, default 4: number of mailboxes, 2..16.
- `IFS_CYCLES`, default 3: recessive intermission cycles required before a new start, ≥1.
- `MAX_RETRY`, default 8: failed attempts before abort; used only with `TX_RETRY_LIMIT_EN`.

Ports:
- `clock`  in  1: single clock.
- `reset`  in  1: asynchronous, active-high.
- `req`  in  NUM_MB: level request per mailbox; held until `grant_done` or `grant_abort` for that mailbox.
- `id`  in  11*NUM_MB: mailbox i identifier at `[11*i +: 11]`; stable while `req[i]`=1.
- `tx_start`  out  1: one-cycle start pulse to the transmitter.
- `tx_id`  out  11: identifier of the granted frame.
- `tx_sel`  out  $clog2(NUM_MB): index of the granted mailbox.
- `tx_busy`  in  1: transmitter is driving a frame (SOF through EOF).
- `tx_done`  in  1: pulse, frame completed with ACK.
- `tx_arb_lost`  in  1: pulse, arbitration lost.
- `tx_error`  in  1: pulse, bit/stuff/ACK error detected.
- `grant_done`  out  NUM_MB: one-hot pulse, mailbox frame sent.
- `grant_abort`  out  NUM_MB: one-hot pulse, mailbox abandoned.
- `sched_busy`  out  1: high in any state other than IDLE.

## Operation
- States: IDLE, START, ACTIVE, HOLDOFF.
- Reset: state IDLE. All outputs 0, including `tx_id` and `tx_sel`. Abort mask, retry counter and holdoff counter are cleared.
- Eligibility: mailbox i is eligible when `req[i]`=1 and `mask[i]`=0.
- Selection: the eligible mailbox with minimum `id` wins. An equal `id` is resolved to the lowest index.
- IDLE: when any mailbox is eligible, latch the winner's `tx_id`/`tx_sel` and go to START.
- START: `tx_start`=1 for exactly this one cycle; go to ACTIVE.
- ACTIVE: wait for an outcome pulse. When several pulses arrive in the same cycle, the precedence is `tx_error` > `tx_arb_lost` > `tx_done`.
  - `tx_done`: pulse `grant_done[tx_sel]`, clear the retry counter, go to HOLDOFF.
  - `tx_arb_lost` or `tx_error`: increment the retry counter, go to HOLDOFF. The mailbox stays pending and competes again.
- HOLDOFF: the counter loads `IFS_CYCLES` on entry and decrements only in cycles with `tx_busy`=0. At 0, go to IDLE and re-arbitrate over all mailboxes, so a higher-priority request arriving mid-frame wins next.
- Retry counter: 4 bits, saturating. It is cleared when IDLE latches a mailbox index different from the previous `tx_sel`.
- A `req[i]` drop during START/ACTIVE does not cancel the frame. The outcome pulses are still generated.
- `tx_id`/`tx_sel` hold their value from START until the next IDLE selection.
- `tx_done`/`tx_arb_lost`/`tx_error` are ignored outside ACTIVE.
- Mask: `mask[i]` is set on `grant_abort[i]` and cleared in any cycle with `req[i]`=0.

## Timing
- Request latency: a request sampled at edge k in IDLE gives START after edge k, with `tx_start` high from edge k to edge k+1.
- Outcome latency: an outcome pulse sampled at edge m in ACTIVE gives `grant_done`/`grant_abort` high from edge m to edge m+1, and HOLDOFF from edge m.
- Minimum gap: with `tx_busy` low, HOLDOFF lasts `IFS_CYCLES` cycles, so the minimum gap between `tx_start` pulses is `IFS_CYCLES`+2 cycles.
- `tx_busy` high during HOLDOFF stalls the countdown; the count resumes, not reloads.
- Mailbox clear: requesters clear `req` within `IFS_CYCLES` cycles after `grant_done`, otherwise the frame is retransmitted.
- Reset asserted in any state: next state IDLE immediately. Any in-flight outcome pulse is dropped; no `grant_*` is issued.

## Configuration
- `TX_RETRY_LIMIT_EN` defined:
  - When a failure brings the retry counter to `MAX_RETRY`, pulse `grant_abort[tx_sel]` in the same cycle as the HOLDOFF entry.
  - Set `mask[tx_sel]` and clear the retry counter.
- `TX_RETRY_LIMIT_EN` undefined:
  - Unlimited retries.
  - `grant_abort` is tied to 0; the mask logic is absent.
  - The retry counter still counts, for debug visibility only.

## Test plan
- Reset with `req`=0 → all outputs 0 and IDLE. Then `req[2]`=1 with `id2`=0x123 → `tx_start` one cycle later, `tx_id`=0x123, `tx_sel`=2.
- `req`=4'b1111 with ids 0x300, 0x050, 0x050, 0x7FF → grant order 1, 2, 0, 3. Each follows a `tx_done`. Each start is ≥`IFS_CYCLES`+2 cycles after the previous one.
- Mailbox 0 (0x200) loses arbitration while mailbox 3 (0x010) is raised mid-frame → the next grant is mailbox 3; mailbox 0 follows after its `tx_done`.
- `tx_done` and `tx_error` in the same cycle → no `grant_done`, retry counter =1, mailbox retransmitted.
- With `TX_RETRY_LIMIT_EN` and `MAX_RETRY`=8: 8 `tx_error` pulses on mailbox 1 → `grant_abort[1]` pulse, mailbox 1 not re-granted until `req[1]` drops and rises. Without the macro: a 9th start occurs.
- Assert `reset` during ACTIVE, with `tx_busy` held high and `tx_done` pulsed in the same cycle → `sched_busy`=0 and no `grant_done`. Requests still pending are re-granted after reset release.

Source files
------------

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: shares one CAN frame transmitter among NUM_MB transmit
// mailboxes. Grants the pending mailbox with the lowest 11-bit identifier.
// A tie on identifier goes to the lower mailbox index. The winner is handed
// to the transmitter with a one-cycle start pulse. After the outcome pulse the
// block waits out the interframe holdoff, then re-arbitrates.
//
// Optional feature macro: TX_RETRY_LIMIT_EN
//   defined   : after MAX_RETRY failed attempts the mailbox is aborted
//               (grant_abort pulse) and masked until its request drops.
//   undefined : retries are unlimited and grant_abort is tied low. The retry
//               counter still counts, for debug visibility only.

module can_tx_scheduler #(
  parameter int unsigned NUM_MB     = 4,
  parameter int unsigned IFS_CYCLES = 3,
  parameter int unsigned MAX_RETRY  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MB-1:0]         req,
  input  logic [11*NUM_MB-1:0]      id,
  output logic                      tx_start,
  output logic [10:0]               tx_id,
  output logic [$clog2(NUM_MB)-1:0] tx_sel,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  input  logic                      tx_arb_lost,
  input  logic                      tx_error,
  output logic [NUM_MB-1:0]         grant_done,
  output logic [NUM_MB-1:0]         grant_abort,
  output logic                      sched_busy
);

  localparam int unsigned SEL_W  = $clog2(NUM_MB);
  localparam int unsigned ID_W   = 11;
  localparam int unsigned HOLD_W = $clog2(IFS_CYCLES + 1);
  localparam int unsigned RTRY_W = 4;

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(IFS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [RTRY_W-1:0] RTRY_SAT  = RTRY_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t              state_q;
  logic                tx_start_q;
  logic [ID_W-1:0]     tx_id_q;
  logic [SEL_W-1:0]    tx_sel_q;
  logic [NUM_MB-1:0]   grant_done_q;
  logic                sched_busy_q;
  logic [RTRY_W-1:0]   retry_q;
  logic [HOLD_W-1:0]   hold_q;

  logic [NUM_MB-1:0]   eligible;
  logic                win_found;
  logic [SEL_W-1:0]    win_sel;
  logic [ID_W-1:0]     win_id;
  logic [NUM_MB-1:0]   sel_onehot;
  logic [RTRY_W-1:0]   retry_inc;

`ifdef TX_RETRY_LIMIT_EN
  localparam logic [RTRY_W-1:0] RETRY_LIMIT = RTRY_W'(MAX_RETRY);

  logic [NUM_MB-1:0]   grant_abort_q;
  logic [NUM_MB-1:0]   mask_q;

  // Aborted mailboxes stay masked until their request is withdrawn.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else begin
      mask_q <= (mask_q & req) | grant_abort_q;
    end
  end

  assign eligible    = req & ~mask_q;
  assign grant_abort = grant_abort_q;
`else
  // Without the retry limit MAX_RETRY has no function; sink it explicitly.
  logic [RTRY_W-1:0]   unused_max_retry;
  assign unused_max_retry = RTRY_W'(MAX_RETRY);

  assign eligible    = req;
  assign grant_abort = '0;
`endif

  // Minimum-identifier search; strict compare keeps the lowest index on ties.
  always_comb begin
    win_found = 1'b0;
    win_sel   = '0;
    win_id    = '0;
    for (int i = 0; i < int'(NUM_MB); i++) begin
      if (eligible[i] && (!win_found || (id[ID_W*i +: ID_W] < win_id))) begin
        win_found = 1'b1;
        win_sel   = SEL_W'(i);
        win_id    = id[ID_W*i +: ID_W];
      end
    end
  end

  assign sel_onehot = NUM_MB'(1) << tx_sel_q;
  assign retry_inc  = (retry_q == RTRY_SAT) ? retry_q : retry_q + RTRY_W'(1);

  // Scheduler FSM with registered start, grant and busy outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tx_start_q    <= 1'b0;
      tx_id_q       <= '0;
      tx_sel_q      <= '0;
      grant_done_q  <= '0;
      sched_busy_q  <= 1'b0;
      retry_q       <= '0;
      hold_q        <= '0;
`ifdef TX_RETRY_LIMIT_EN
      grant_abort_q <= '0;
`endif
    end else begin
      tx_start_q    <= 1'b0;
      grant_done_q  <= '0;
`ifdef TX_RETRY_LIMIT_EN
      grant_abort_q <= '0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            tx_id_q      <= win_id;
            tx_sel_q     <= win_sel;
            if (win_sel != tx_sel_q) begin
              retry_q <= '0;
            end
            tx_start_q   <= 1'b1;
            sched_busy_q <= 1'b1;
            state_q      <= ST_START;
          end
        end

        ST_START: begin
          state_q <= ST_ACTIVE;
        end

        ST_ACTIVE: begin
          // Failure outranks success when pulses coincide.
          if (tx_error || tx_arb_lost) begin
            hold_q  <= HOLD_INIT;
            state_q <= ST_HOLDOFF;
`ifdef TX_RETRY_LIMIT_EN
            if (retry_inc >= RETRY_LIMIT) begin
              grant_abort_q <= sel_onehot;
              retry_q       <= '0;
            end else begin
              retry_q <= retry_inc;
            end
`else
            retry_q <= retry_inc;
`endif
          end else if (tx_done) begin
            grant_done_q <= sel_onehot;
            retry_q      <= '0;
            hold_q       <= HOLD_INIT;
            state_q      <= ST_HOLDOFF;
          end
        end

        ST_HOLDOFF: begin
          // Countdown pauses while the bus is busy and resumes afterwards.
          if (!tx_busy) begin
            if (hold_q <= HOLD_ONE) begin
              hold_q       <= '0;
              sched_busy_q <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              hold_q <= hold_q - HOLD_ONE;
            end
          end
        end

        default: begin
          sched_busy_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_id      = tx_id_q;
  assign tx_sel     = tx_sel_q;
  assign grant_done = grant_done_q;
  assign sched_busy = sched_busy_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler (NUM_MB=4, IFS_CYCLES=3, MAX_RETRY=8).
module tb_can_tx_scheduler;

  localparam int unsigned NUM_MB    = 4;
  localparam int unsigned IFS       = 3;
  localparam int unsigned MAX_RETRY = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM_MB-1:0] req;
  logic [11*NUM_MB-1:0] id;
  logic              tx_start;
  logic [10:0]       tx_id;
  logic [1:0]        tx_sel;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_arb_lost;
  logic              tx_error;
  logic [NUM_MB-1:0] grant_done;
  logic [NUM_MB-1:0] grant_abort;
  logic              sched_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  can_tx_scheduler #(
    .NUM_MB    (NUM_MB),
    .IFS_CYCLES(IFS),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .id         (id),
    .tx_start   (tx_start),
    .tx_id      (tx_id),
    .tx_sel     (tx_sel),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_arb_lost(tx_arb_lost),
    .tx_error   (tx_error),
    .grant_done (grant_done),
    .grant_abort(grant_abort),
    .sched_busy (sched_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input int i, input logic [10:0] v);
    id[11*i +: 11] = v;
  endtask

  // Waits (bounded) for the start pulse; a timeout shows up as a failed check.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(tx_start), 32'd1);
  endtask

  // Drives one cycle of outcome pulses while the DUT is in ACTIVE.
  task automatic outcome(input logic d, input logic a, input logic e);
    tx_done     = d;
    tx_arb_lost = a;
    tx_error    = e;
    tick();
    tx_done     = 1'b0;
    tx_arb_lost = 1'b0;
    tx_error    = 1'b0;
  endtask

  initial begin
    int exp_sel [4];
    logic [10:0] exp_id [4];
    int last;
    int t0;
    logic seen;

    reset = 1'b1; req = '0; id = '0;
    tx_busy = 1'b0; tx_done = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;
    tick(); tick();
    check("rst_busy_in_reset", 32'(sched_busy), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_id", 32'(tx_id), 32'd0);
    check("rst_tx_sel", 32'(tx_sel), 32'd0);
    check("rst_grant_done", 32'(grant_done), 32'd0);
    check("rst_grant_abort", 32'(grant_abort), 32'd0);
    check("rst_sched_busy", 32'(sched_busy), 32'd0);

    // Single request, one-cycle latency to START.
    set_id(2, 11'h123);
    req = 4'b0100;
    tick();
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_id", 32'(tx_id), 32'h123);
    check("t1_sel", 32'(tx_sel), 32'd2);
    check("t1_busy", 32'(sched_busy), 32'd1);
    tx_done = 1'b1;              // sampled in START: must be ignored
    tick();
    tx_done = 1'b0;
    check("t1_start_one_cycle", 32'(tx_start), 32'd0);
    check("t1_done_ignored", 32'(grant_done), 32'd0);
    outcome(1'b1, 1'b0, 1'b0);
    check("t1_grant_done", 32'(grant_done), 32'h4);
    req = '0;
    tick(); tick();
    check("t1_holdoff_busy", 32'(sched_busy), 32'd1);
    tick();
    check("t1_idle_after_ifs", 32'(sched_busy), 32'd0);

    // Priority order with an id tie resolved by index.
    set_id(0, 11'h300); set_id(1, 11'h050); set_id(2, 11'h050); set_id(3, 11'h7FF);
    exp_sel = '{1, 2, 0, 3};
    exp_id  = '{11'h050, 11'h050, 11'h300, 11'h7FF};
    req = 4'b1111;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("t2_start%0d", k));
      check($sformatf("t2_sel%0d", k), 32'(tx_sel), 32'(exp_sel[k]));
      check($sformatf("t2_id%0d", k), 32'(tx_id), 32'(exp_id[k]));
      if (k > 0) begin
        // low cycles between consecutive start pulses
        check($sformatf("t2_gap%0d", k), 32'(cyc - last - 1), 32'(IFS + 2));
      end
      last = cyc;
      tick();
      outcome(1'b1, 1'b0, 1'b0);
      check($sformatf("t2_grant%0d", k), 32'(grant_done), 32'(4'b0001 << exp_sel[k]));
      req[exp_sel[k]] = 1'b0;
    end

    // Arbitration loss while a higher-priority request arrives mid-frame.
    set_id(0, 11'h200);
    req = 4'b0001;
    wait_start("t3_start_mb0");
    check("t3_sel_mb0", 32'(tx_sel), 32'd0);
    tick();
    set_id(3, 11'h010);
    req[3] = 1'b1;
    tx_busy = 1'b1;
    tick();
    outcome(1'b0, 1'b1, 1'b0);
    check("t3_arb_no_grant", 32'(grant_done), 32'd0);
    t0 = cyc;
    tx_busy = 1'b0; tick();            // 3 -> 2
    tx_busy = 1'b1; tick(); tick();    // stalled
    tx_busy = 1'b0;
    wait_start("t3_start_mb3");
    check("t3_holdoff_resume", 32'(cyc - t0), 32'd6);
    check("t3_sel_mb3", 32'(tx_sel), 32'd3);
    check("t3_id_mb3", 32'(tx_id), 32'h010);
    tick();
    outcome(1'b1, 1'b0, 1'b0);
    check("t3_grant_mb3", 32'(grant_done), 32'h8);
    req[3] = 1'b0;
    wait_start("t3_restart_mb0");
    check("t3_resel_mb0", 32'(tx_sel), 32'd0);
    tick();
    outcome(1'b1, 1'b0, 1'b0);
    check("t3_grant_mb0", 32'(grant_done), 32'h1);
    req[0] = 1'b0;

    // Done and error together: error wins, retry counts, frame retried.
    set_id(1, 11'h100);
    req = 4'b0010;
    wait_start("t4_start");
    check("t4_sel", 32'(tx_sel), 32'd1);
    tick();
    outcome(1'b1, 1'b0, 1'b1);
    check("t4_no_grant", 32'(grant_done), 32'd0);
    check("t4_retry1", 32'(dut.retry_q), 32'd1);
    for (int a = 2; a <= 8; a++) begin
      wait_start($sformatf("t5_start%0d", a));
      check($sformatf("t5_sel%0d", a), 32'(tx_sel), 32'd1);
      tick();
      outcome(1'b0, 1'b0, 1'b1);
    end
`ifdef TX_RETRY_LIMIT_EN
    check("t5_abort", 32'(grant_abort), 32'h2);
    check("t5_retry_clr", 32'(dut.retry_q), 32'd0);
    seen = 1'b0;
    for (int w = 0; w < 12; w++) begin
      tick();
      seen = seen | tx_start;
    end
    check("t5_masked_no_start", 32'(seen), 32'd0);
    check("t5_masked_idle", 32'(sched_busy), 32'd0);
    req[1] = 1'b0;
    tick(); tick();
    req[1] = 1'b1;
    wait_start("t5_regrant");
    check("t5_regrant_sel", 32'(tx_sel), 32'd1);
    tick();
    outcome(1'b1, 1'b0, 1'b0);
    check("t5_regrant_done", 32'(grant_done), 32'h2);
`else
    check("t5_no_abort", 32'(grant_abort), 32'd0);
    check("t5_retry8", 32'(dut.retry_q), 32'd8);
    seen = 1'b0;
    wait_start("t5_start9");
    check("t5_sel9", 32'(tx_sel), 32'd1);
    tick();
    outcome(1'b1, 1'b0, 1'b0);
    check("t5_done9", 32'(grant_done), 32'h2);
    check("t5_retry_clr", 32'(dut.retry_q), 32'd0 | 32'(seen));
`endif
    req = '0;

    // Reset during ACTIVE drops the in-flight outcome.
    set_id(2, 11'h123); set_id(0, 11'h400);
    req = 4'b0101;
    wait_start("t6_start");
    check("t6_sel", 32'(tx_sel), 32'd2);
    tick();
    tx_busy = 1'b1;
    tx_done = 1'b1;
    reset   = 1'b1;
    #1;
    check("t6_async_busy", 32'(sched_busy), 32'd0);
    tick();
    tx_done = 1'b0;
    check("t6_no_grant", 32'(grant_done), 32'd0);
    check("t6_no_start", 32'(tx_start), 32'd0);
    check("t6_sel_clr", 32'(tx_sel), 32'd0);
    reset   = 1'b0;
    tx_busy = 1'b0;
    wait_start("t6_regrant");
    check("t6_regrant_sel", 32'(tx_sel), 32'd2);
    tick();
    outcome(1'b1, 1'b0, 1'b0);
    check("t6_grant_mb2", 32'(grant_done), 32'h4);
    req[2] = 1'b0;
    wait_start("t6_start_mb0");
    check("t6_sel_mb0", 32'(tx_sel), 32'd0);
    tick();
    outcome(1'b1, 1'b0, 1'b0);
    check("t6_grant_mb0", 32'(grant_done), 32'h1);
    req = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
